// File: rtl/pipe_sequencer_pkg.sv
// pipe_seq_pkg: sequencer state encoding and default parameters
package pipe_seq_pkg;
  typedef enum logic [2:0] {BOOT = 3'd0, RUN = 3'd1, MCWAIT = 3'd2, DRAIN = 3'd3, HALT = 3'd4} state_e;
  localparam int BOOT_CYCLES_DEF = 4;
  localparam int DRAIN_CYCLES_DEF = 3;
  localparam int MC_TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/pipe_sequencer_if.sv
// pipe_sequencer_if: hazard/EX/halt requests in, per-stage enables, bubbles and debug state out
interface pipe_sequencer_if import pipe_seq_pkg::*; #(parameter int CNT_W = CNT_W_DEF);
  logic hz_stall, annul_ds, mc_start, mc_done, halt_req;
  logic pc_le, ifid_le, idex_le, exmem_le, memwb_le;
  logic ifid_nop, idex_nop, exmem_nop;
  logic halted, mc_err;
  logic [2:0] state_o;
  logic [CNT_W-1:0] stall_cnt, annul_cnt, mc_cyc_cnt;
  modport master (
    output hz_stall, annul_ds, mc_start, mc_done, halt_req,
    input  pc_le, ifid_le, idex_le, exmem_le, memwb_le, ifid_nop, idex_nop, exmem_nop,
    input  halted, mc_err, state_o, stall_cnt, annul_cnt, mc_cyc_cnt
  );
  modport slave (
    input  hz_stall, annul_ds, mc_start, mc_done, halt_req,
    output pc_le, ifid_le, idex_le, exmem_le, memwb_le, ifid_nop, idex_nop, exmem_nop,
    output halted, mc_err, state_o, stall_cnt, annul_cnt, mc_cyc_cnt
  );
endinterface

// File: rtl/pipe_sequencer_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(parameter int CNT_W = 16) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] value
);
  logic [CNT_W-1:0] value_q, value_d;
  always_comb value_d = clear ? '0 : (inc && !(&value_q)) ? value_q + 1'b1 : value_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value_q <= '0;
    else value_q <= value_d;
  assign value = value_q;
endmodule

// File: rtl/pipe_sequencer.sv
// pipe_sequencer: per-stage load enables and bubble injects for the five-stage pipeline
module pipe_sequencer import pipe_seq_pkg::*; #(
  parameter int BOOT_CYCLES  = BOOT_CYCLES_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int MC_TIMEOUT   = MC_TIMEOUT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input logic clk,
  input logic rst_n,
  pipe_sequencer_if.slave sq
);
  localparam int CW = $clog2(BOOT_CYCLES + DRAIN_CYCLES + MC_TIMEOUT + 1);
  state_e state_q, state_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic mc_err_q, mc_err_d, halted_q, halted_d;
  logic stall_inc, annul_inc, mc_inc, mc_go;
  assign mc_go = sq.mc_start && !sq.mc_done;
  // one timer serves boot, drain and watchdog: it restarts on every state change
  always_comb begin
    state_d = state_q;
    tmr_d = tmr_q + 1'b1;
    mc_err_d = mc_err_q;
    {sq.pc_le, sq.ifid_le, sq.idex_le, sq.exmem_le, sq.memwb_le} = 5'b11111;
    {sq.ifid_nop, sq.idex_nop, sq.exmem_nop} = 3'b000;
    {stall_inc, annul_inc, mc_inc} = 3'b000;
    case (state_q)
      BOOT: begin
        sq.pc_le = 1'b0;
        {sq.ifid_nop, sq.idex_nop, sq.exmem_nop} = 3'b111;
        if (tmr_q == CW'(BOOT_CYCLES - 1)) state_d = RUN;
      end
      RUN, DRAIN: begin
        if (mc_go) begin
          {sq.pc_le, sq.ifid_le, sq.idex_le, sq.exmem_nop} = 4'b0001;
          state_d = MCWAIT;
        end else if (sq.hz_stall) begin
          {sq.pc_le, sq.ifid_le, sq.idex_nop} = 3'b001;
          stall_inc = 1'b1;
          tmr_d = tmr_q;
        end else if (state_q == DRAIN) begin
          {sq.pc_le, sq.ifid_nop} = 2'b01;
          if (tmr_q == CW'(DRAIN_CYCLES - 1)) state_d = HALT;
        end else if (sq.annul_ds) begin
          sq.ifid_nop = 1'b1;
          annul_inc = 1'b1;
        end else if (sq.halt_req) begin
          {sq.pc_le, sq.ifid_nop} = 2'b01;
          state_d = DRAIN;
        end
      end
      MCWAIT: begin
        mc_inc = 1'b1;
        if (sq.mc_done) state_d = RUN;
        else if (tmr_q == CW'(MC_TIMEOUT - 1)) begin
          sq.exmem_nop = 1'b1;
          mc_err_d = 1'b1;
          state_d = RUN;
        end else {sq.pc_le, sq.ifid_le, sq.idex_le, sq.exmem_nop} = 4'b0001;
      end
      HALT: begin
        {sq.pc_le, sq.ifid_le, sq.idex_le, sq.exmem_le, sq.memwb_le} = 5'b00000;
        if (!sq.halt_req) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
    if (state_d != state_q) tmr_d = '0;
    halted_d = state_d == HALT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= BOOT;
      tmr_q <= '0;
      mc_err_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      mc_err_q <= mc_err_d;
      halted_q <= halted_d;
    end
  assign sq.state_o = state_q;
  assign sq.mc_err = mc_err_q;
  assign sq.halted = halted_q;
  sat_counter #(.CNT_W(CNT_W)) u_stall (.clk(clk), .rst_n(rst_n), .inc(stall_inc), .clear(1'b0), .value(sq.stall_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_annul (.clk(clk), .rst_n(rst_n), .inc(annul_inc), .clear(1'b0), .value(sq.annul_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_mc (.clk(clk), .rst_n(rst_n), .inc(mc_inc), .clear(1'b0), .value(sq.mc_cyc_cnt));
endmodule

// File: tb/tb_pipe_sequencer.sv
// tb_pipe_sequencer: directed vector table plus watchdog, saturation and reset sequences
module tb_pipe_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  pipe_sequencer_if #(.CNT_W(16)) m ();
  pipe_sequencer_if #(.CNT_W(2)) s ();
  pipe_sequencer #(.CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .sq(m));
  pipe_sequencer #(.CNT_W(2)) dut_s (.clk(clk), .rst_n(rst_n), .sq(s));
  assign s.hz_stall = m.hz_stall;
  assign s.annul_ds = m.annul_ds;
  assign s.mc_start = m.mc_start;
  assign s.mc_done = m.mc_done;
  assign s.halt_req = m.halt_req;
  always #5 clk = ~clk;
  typedef struct packed {
    logic [4:0]  in;
    logic [12:0] exp;
  } vec_t;
  vec_t v [26];
  function automatic logic [12:0] mk(logic [4:0] le, logic [2:0] nop, logic h, logic e, logic [2:0] st);
    return {le, nop, h, e, st};
  endfunction
  function automatic logic [12:0] outs();
    return {m.pc_le, m.ifid_le, m.idex_le, m.exmem_le, m.memwb_le,
            m.ifid_nop, m.idex_nop, m.exmem_nop, m.halted, m.mc_err, m.state_o};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic drive(logic [4:0] in);
    {m.hz_stall, m.annul_ds, m.mc_start, m.mc_done, m.halt_req} = in;
  endtask
  initial begin
    logic [12:0] bt, nr, st, fz, dr, hl;
    bt = mk(5'b01111, 3'b111, 1'b0, 1'b0, 3'd0);
    nr = mk(5'b11111, 3'b000, 1'b0, 1'b0, 3'd1);
    st = mk(5'b00111, 3'b010, 1'b0, 1'b0, 3'd1);
    fz = mk(5'b00011, 3'b001, 1'b0, 1'b0, 3'd1);
    dr = mk(5'b01111, 3'b100, 1'b0, 1'b0, 3'd3);
    hl = mk(5'b00000, 3'b000, 1'b1, 1'b0, 3'd4);
    v[0] = '{5'b00000, bt};
    v[1] = '{5'b00000, bt};
    v[2] = '{5'b10001, bt};
    v[3] = '{5'b00000, bt};
    v[4] = '{5'b00000, nr};
    v[5] = '{5'b10000, st};
    v[6] = '{5'b10000, st};
    v[7] = '{5'b11000, st};
    v[8] = '{5'b01000, mk(5'b11111, 3'b100, 1'b0, 1'b0, 3'd1)};
    v[9] = '{5'b00100, fz};
    for (int i = 10; i < 14; i++) v[i] = '{5'b00000, mk(5'b00011, 3'b001, 1'b0, 1'b0, 3'd2)};
    v[14] = '{5'b00010, mk(5'b11111, 3'b000, 1'b0, 1'b0, 3'd2)};
    v[15] = '{5'b00000, nr};
    v[16] = '{5'b00110, nr};
    v[17] = '{5'b00000, nr};
    v[18] = '{5'b00001, mk(5'b01111, 3'b100, 1'b0, 1'b0, 3'd1)};
    v[19] = '{5'b00001, dr};
    v[20] = '{5'b00001, dr};
    v[21] = '{5'b10001, mk(5'b00111, 3'b010, 1'b0, 1'b0, 3'd3)};
    v[22] = '{5'b00001, dr};
    v[23] = '{5'b00001, hl};
    v[24] = '{5'b00000, hl};
    v[25] = '{5'b00000, nr};
    drive(5'b00000);
    #3;
    chk("reset_outs", 32'(outs()), 32'(bt));
    chk("reset_cnts", {m.stall_cnt, m.annul_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 26; i++) begin
      drive(v[i].in);
      #1;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(v[i].exp));
      @(negedge clk);
    end
    chk("stall_cnt", 32'(m.stall_cnt), 32'd4);
    chk("annul_cnt", 32'(m.annul_cnt), 32'd1);
    chk("mc_cyc_cnt", 32'(m.mc_cyc_cnt), 32'd5);
    chk("sat_stall", 32'(s.stall_cnt), 32'd3);
    chk("sat_annul", 32'(s.annul_cnt), 32'd1);
    chk("sat_mc", 32'(s.mc_cyc_cnt), 32'd3);
    drive(5'b00100);
    #1;
    chk("wd_start", 32'(outs()), 32'(fz));
    @(negedge clk);
    drive(5'b00000);
    for (int i = 1; i <= 64; i++) begin
      #1;
      chk($sformatf("wd%0d", i), 32'(outs()),
          32'(i < 64 ? mk(5'b00011, 3'b001, 1'b0, 1'b0, 3'd2) : mk(5'b11111, 3'b001, 1'b0, 1'b0, 3'd2)));
      @(negedge clk);
    end
    #1;
    chk("wd_after", 32'(outs()), 32'(mk(5'b11111, 3'b000, 1'b0, 1'b1, 3'd1)));
    chk("wd_mc_cyc", 32'(m.mc_cyc_cnt), 32'd69);
    @(negedge clk);
    #1;
    chk("wd_sticky", 32'(m.mc_err), 32'd1);
    drive(5'b00001);
    for (int i = 0; i < 5; i++) @(negedge clk);
    #1;
    chk("halt_again", 32'(outs()), 32'(mk(5'b00000, 3'b000, 1'b1, 1'b1, 3'd4)));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 32'(outs()), 32'(bt));
    chk("async_rst_cnt", {m.stall_cnt, m.mc_cyc_cnt}, 32'd0);
    @(negedge clk);
    drive(5'b00000);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge clk);
    #1;
    chk("reboot_run", 32'(outs()), 32'(nr));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
